// File: rtl/dcache_port_arb_pkg.sv
// Shared types and sizing for the D-cache port arbiter and its retired-store write buffer.
package dcache_port_arb_pkg;

  localparam int XLEN         = 32;
  localparam int WB_DEPTH     = 8;
  localparam int WB_HIGH      = 6;
  localparam int STARVE_LIMIT = 4;
  localparam int WB_CW        = $clog2(WB_DEPTH) + 1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } BUS_CMD;

  typedef struct packed {
    logic            ready;
    logic [XLEN-1:0] addr;
    logic [3:0]      usebytes;
    logic [XLEN-1:0] data;
  } SQ_ENTRY_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [3:0]      usebytes;
    logic [XLEN-1:0] data;
  } WB_ENTRY;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/dcache_port_arb_if.sv
// Retire, load-FU and cache-port signals of the D-cache port arbiter.
interface dcache_port_arb_if;
  import dcache_port_arb_pkg::*;

  logic [2:0]            retire;
  SQ_ENTRY_PACKET [2:0]  cache_wb;
  logic [2:0]            wb_stall;
  logic [1:0]            ld_req;
  logic [1:0][XLEN-1:0]  ld_addr;
  logic [1:0]            ld_gnt;
  BUS_CMD                mem_cmd;
  logic [XLEN-1:0]       mem_addr;
  logic [XLEN-1:0]       mem_data;
  logic [3:0]            mem_usebytes;
  logic                  mem_accept;
  logic                  halt_drain;
  logic                  wb_empty;

  modport master (
    output retire, cache_wb, ld_req, ld_addr, mem_accept, halt_drain,
    input  wb_stall, ld_gnt, mem_cmd, mem_addr, mem_data, mem_usebytes, wb_empty
  );

  modport slave (
    input  retire, cache_wb, ld_req, ld_addr, mem_accept, halt_drain,
    output wb_stall, ld_gnt, mem_cmd, mem_addr, mem_data, mem_usebytes, wb_empty
  );

endinterface

// File: rtl/dcache_port_arb_wb_fifo.sv
// In-order write buffer: up to 3 pushes and 1 pop per cycle, entries visible the cycle after push.
// No internal backpressure; the caller masks pushes against free and pops only when nonempty.
module wb_fifo
  import dcache_port_arb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       push,
  input  WB_ENTRY          push_dat [3],
  input  logic             pop,
  output logic [XLEN-3:0]  entry_tag [DEPTH],
  output logic [DEPTH-1:0] valid,
  output WB_ENTRY          head_dat,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free
);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  WB_ENTRY       mem [DEPTH];

  // Slot tail+i takes retire lane i; lanes are contiguous so no gaps appear.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[tail + AW'(i)] <= push_dat[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(popcount3(push));
      count <= count + CW'(popcount3(push)) - CW'(pop);
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_valid
    logic [AW-1:0] off;
    assign off          = AW'(j) - head;
    assign valid[j]     = {1'b0, off} < count;
    assign entry_tag[j] = mem[j].addr[XLEN-1:2];
  end

  assign head_dat = mem[head];
  assign free     = CW'(DEPTH) - count;

endmodule

// File: rtl/dcache_port_arb.sv
// Shares the single D-cache port between buffered retired stores and two load FUs; the command is
// combinational from registered state, completes on mem_accept, and retire is throttled by wb_stall.
module dcache_port_arb
  import dcache_port_arb_pkg::*;
(
  input logic               clock,
  input logic               reset,
  dcache_port_arb_if.slave  bus
);

  localparam int CW = WB_CW;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [2:0]          stall;
  logic [2:0]          push;
  WB_ENTRY             push_dat [3];
  logic [XLEN-3:0]     entry_tag [WB_DEPTH];
  logic [WB_DEPTH-1:0] valid;
  WB_ENTRY             head_dat;
  logic [CW-1:0]       count;
  logic [CW-1:0]       free;

  logic [1:0]    ld_alias;
  logic [1:0]    ld_cand;
  logic          nonempty;
  logic          force_store;
  logic          sel_store;
  logic          sel_load;
  logic          sel_k;
  logic          store_done;
  logic          load_done;
  logic [SW-1:0] starve;
  logic          rr;
  logic          unused_ready;

  // Throttle uses registered free only; a pop this cycle is not credited.
  always_comb begin
    stall = 3'b000;
    if (free == '0)            stall = 3'b111;
    else if (free == CW'(1))   stall = 3'b110;
    else if (free == CW'(2))   stall = 3'b100;
  end

  assign push = bus.retire & ~stall;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      push_dat[i] = '{addr:     bus.cache_wb[i].addr,
                      usebytes: bus.cache_wb[i].usebytes,
                      data:     bus.cache_wb[i].data};
    end
  end

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (store_done),
    .entry_tag (entry_tag),
    .valid     (valid),
    .head_dat  (head_dat),
    .count     (count),
    .free      (free)
  );

  // A load may not bypass a buffered store to the same word.
  always_comb begin
    ld_alias = '0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < WB_DEPTH; j++) begin
        if (valid[j] && entry_tag[j] == bus.ld_addr[k][XLEN-1:2]) ld_alias[k] = 1'b1;
      end
    end
  end

  assign nonempty = (count != '0);

  always_comb begin
    sel_store   = 1'b0;
    sel_load    = 1'b0;
    sel_k       = 1'b0;
    ld_cand     = bus.ld_req & ~ld_alias & {2{~bus.halt_drain}};
    force_store = nonempty && (count >= CW'(WB_HIGH) || starve == SW'(STARVE_LIMIT) ||
                               bus.halt_drain || |(bus.ld_req & ld_alias));
    if (reset) begin
      if (force_store) begin
        sel_store = 1'b1;
      end else if (|ld_cand) begin
        sel_load = 1'b1;
        sel_k    = (ld_cand == 2'b11) ? rr : ld_cand[1];
      end else if (nonempty) begin
        sel_store = 1'b1;
      end
    end
  end

  assign store_done = sel_store && bus.mem_accept;
  assign load_done  = sel_load && bus.mem_accept;

  always_comb begin
    bus.mem_cmd      = BUS_NONE;
    bus.mem_addr     = '0;
    bus.mem_data     = '0;
    bus.mem_usebytes = '0;
    bus.ld_gnt       = '0;
    if (sel_store) begin
      bus.mem_cmd      = BUS_STORE;
      bus.mem_addr     = head_dat.addr;
      bus.mem_data     = head_dat.data;
      bus.mem_usebytes = head_dat.usebytes;
    end else if (sel_load) begin
      bus.mem_cmd       = BUS_LOAD;
      bus.mem_addr      = bus.ld_addr[sel_k];
      bus.ld_gnt[sel_k] = bus.mem_accept;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve <= '0;
      rr     <= 1'b0;
    end else begin
      if (store_done || !nonempty)
        starve <= '0;
      else if (load_done && starve != SW'(STARVE_LIMIT))
        starve <= starve + SW'(1);
      if (load_done) rr <= ~sel_k;
    end
  end

  assign bus.wb_stall = stall;
  assign bus.wb_empty = !nonempty;

  assign unused_ready = ^{bus.cache_wb[0].ready, bus.cache_wb[1].ready, bus.cache_wb[2].ready};

endmodule

// File: tb/tb_dcache_port_arb.sv
// Bench for dcache_port_arb: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_dcache_port_arb;
  import dcache_port_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dcache_port_arb_if bus();

  dcache_port_arb dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  WB_ENTRY    mq[$];
  int         m_starve = 0;
  int         m_rr = 0;
  logic [1:0] gnt_seen = '0;

  int          mn, m_free, m_allow, m_k;
  logic        m_st, m_ld;
  logic [1:0]  m_alias, m_cand, e_cmd, e_gnt;
  logic [2:0]  e_stall;
  logic [31:0] e_addr, e_data;
  logic [3:0]  e_ube;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs from the queue contents, then advance for the coming edge.
  always @(negedge clock) begin
    gnt_seen = bus.ld_gnt;
    mn      = mq.size();
    m_free  = WB_DEPTH - mn;
    e_stall = (m_free == 0) ? 3'b111 : (m_free == 1) ? 3'b110 : (m_free == 2) ? 3'b100 : 3'b000;
    e_cmd = 2'b00; e_addr = '0; e_data = '0; e_ube = '0; e_gnt = '0;
    m_st = 1'b0; m_ld = 1'b0; m_k = 0;
    if (!reset) begin
      mq.delete();
      m_starve = 0;
      m_rr     = 0;
      e_stall  = 3'b000;
      mn       = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_alias[k] = 1'b0;
        foreach (mq[j]) if (mq[j].addr[31:2] == bus.ld_addr[k][31:2]) m_alias[k] = 1'b1;
      end
      m_cand = bus.ld_req & ~m_alias & {2{~bus.halt_drain}};
      if (mn > 0 && (mn >= WB_HIGH || m_starve == STARVE_LIMIT || bus.halt_drain ||
                     (bus.ld_req & m_alias) != 2'b00)) m_st = 1'b1;
      else if (m_cand != 2'b00) begin
        m_ld = 1'b1;
        m_k  = (m_cand == 2'b11) ? m_rr : (m_cand[1] ? 1 : 0);
      end else if (mn > 0) m_st = 1'b1;
      if (m_st) begin
        e_cmd = 2'b10; e_addr = mq[0].addr; e_data = mq[0].data; e_ube = mq[0].usebytes;
      end
      if (m_ld) begin
        e_cmd = 2'b01; e_addr = bus.ld_addr[m_k]; e_gnt[m_k] = bus.mem_accept;
      end
    end
    chk("mdl_cmd",      bus.mem_cmd,      e_cmd);
    chk("mdl_addr",     bus.mem_addr,     e_addr);
    chk("mdl_data",     bus.mem_data,     e_data);
    chk("mdl_ube",      bus.mem_usebytes, e_ube);
    chk("mdl_gnt",      bus.ld_gnt,       e_gnt);
    chk("mdl_stall",    bus.wb_stall,     e_stall);
    chk("mdl_empty",    bus.wb_empty,     mn == 0);
    if (reset) begin
      m_allow = (m_free >= 3) ? 3 : m_free;
      if ((m_st && bus.mem_accept) || mn == 0) m_starve = 0;
      else if (m_ld && bus.mem_accept && m_starve < STARVE_LIMIT) m_starve++;
      if (m_ld && bus.mem_accept) m_rr = 1 - m_k;
      if (m_st && bus.mem_accept) void'(mq.pop_front());
      for (int i = 0; i < 3; i++) begin
        if (bus.retire[i] && i < m_allow)
          mq.push_back('{addr: bus.cache_wb[i].addr, usebytes: bus.cache_wb[i].usebytes,
                         data: bus.cache_wb[i].data});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_wb(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.cache_wb[i] = '{ready: 1'b1, addr: a, usebytes: be, data: d};
  endtask

  function automatic logic [31:0] rand_addr();
    return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  logic [31:0] t1a [3];
  logic [1:0]  t3g [3];
  int          cnt, nr;
  logic        seen;

  initial begin
    t1a = '{32'h10, 32'h28, 32'h78};
    t3g = '{2'b10, 2'b01, 2'b10};
    bus.retire = '0; bus.cache_wb = '0; bus.ld_req = '0; bus.ld_addr = '0;
    bus.mem_accept = 1'b0; bus.halt_drain = 1'b0;

    // 1: reset values, then three stores in retire order
    #2 reset = 1'b0;
    #1;
    chk("rst_stall", bus.wb_stall, 3'b000);
    chk("rst_cmd",   bus.mem_cmd,  BUS_NONE);
    chk("rst_empty", bus.wb_empty, 1'b1);
    chk("rst_gnt",   bus.ld_gnt,   2'b00);
    repeat (3) step();
    reset = 1'b1;
    settle();
    chk("t1_stall", bus.wb_stall, 3'b000);
    chk("t1_cmd0",  bus.mem_cmd,  BUS_NONE);
    chk("t1_empty0", bus.wb_empty, 1'b1);
    bus.retire = 3'b111; bus.mem_accept = 1'b1;
    for (int i = 0; i < 3; i++) set_wb(i, t1a[i], 32'hD000 + 32'(i), 4'hF);
    step();
    bus.retire = 3'b000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_cmd",  bus.mem_cmd,  BUS_STORE);
      chk("t1_addr", bus.mem_addr, t1a[i]);
      step();
    end
    settle();
    chk("t1_empty", bus.wb_empty, 1'b1);
    step();

    // 2: fill with no accepts, throttle encoding, extra retire lane dropped
    bus.mem_accept = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.retire = 3'b111;
      for (int i = 0; i < 3; i++) set_wb(i, 32'h400 + 32'(c * 16 + i * 4), 32'(c * 3 + i), 4'h3);
      settle();
      if (c == 2) chk("t2_stall_free2", bus.wb_stall, 3'b100);
      step();
    end
    bus.retire = 3'b000;
    settle();
    chk("t2_stall_full", bus.wb_stall, 3'b111);
    chk("t2_not_empty",  bus.wb_empty, 1'b0);
    step();
    bus.mem_accept = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (bus.wb_empty) break;
      if (bus.mem_cmd == BUS_STORE) cnt++;
      step();
    end
    chk("t2_drained", bus.wb_empty, 1'b1);
    chk("t2_stores",  cnt, 8);
    step();

    // 3: unaliased load beats a buffered store; round robin alternates
    bus.retire = 3'b001; set_wb(0, 32'h40, 32'hCAFE, 4'hF);
    step();
    bus.retire = 3'b000; bus.ld_req = 2'b01; bus.ld_addr[0] = 32'h20;
    settle();
    chk("t3_ld_cmd",  bus.mem_cmd,  BUS_LOAD);
    chk("t3_ld_addr", bus.mem_addr, 32'h20);
    chk("t3_ld_gnt",  bus.ld_gnt,   2'b01);
    step();
    bus.ld_req = 2'b00;
    settle();
    chk("t3_st_cmd",  bus.mem_cmd,  BUS_STORE);
    chk("t3_st_addr", bus.mem_addr, 32'h40);
    step();
    bus.ld_req = 2'b11; bus.ld_addr[0] = 32'h100; bus.ld_addr[1] = 32'h204;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t3_rr", bus.ld_gnt, t3g[c]);
      step();
    end
    bus.ld_req = 2'b00;

    // 4: aliasing load waits for the store to the same word
    bus.retire = 3'b001; set_wb(0, 32'h38, 32'h1234, 4'h6);
    step();
    bus.retire = 3'b000; bus.ld_req = 2'b01; bus.ld_addr[0] = 32'h3A;
    settle();
    chk("t4_st_cmd",  bus.mem_cmd,  BUS_STORE);
    chk("t4_st_addr", bus.mem_addr, 32'h38);
    chk("t4_blk_gnt", bus.ld_gnt,   2'b00);
    step();
    settle();
    chk("t4_ld_cmd",  bus.mem_cmd,  BUS_LOAD);
    chk("t4_ld_gnt",  bus.ld_gnt,   2'b01);
    step();
    bus.ld_req = 2'b00;

    // 5: starvation forces the store after STARVE_LIMIT load grants
    bus.retire = 3'b001; set_wb(0, 32'h80, 32'h55, 4'h1);
    step();
    bus.retire = 3'b000; bus.ld_req = 2'b11; bus.ld_addr[0] = 32'h100; bus.ld_addr[1] = 32'h200;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (bus.mem_cmd == BUS_STORE) begin seen = 1'b1; break; end
      if (bus.ld_gnt != 2'b00) cnt++;
      step();
    end
    chk("t5_forced", seen, 1'b1);
    chk("t5_grants", cnt, 4);
    step();
    bus.ld_req = 2'b00;

    // 6: halt drains stores only; reset mid-drain empties the buffer at once
    bus.mem_accept = 1'b0; bus.retire = 3'b111;
    for (int i = 0; i < 3; i++) set_wb(i, 32'h300 + 32'(i * 4), 32'h77, 4'hC);
    step();
    bus.retire = 3'b000; bus.halt_drain = 1'b1; bus.mem_accept = 1'b1;
    bus.ld_req = 2'b11; bus.ld_addr[0] = 32'h100; bus.ld_addr[1] = 32'h200;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t6_cmd", bus.mem_cmd, BUS_STORE);
      chk("t6_gnt", bus.ld_gnt,  2'b00);
      step();
    end
    settle();
    chk("t6_empty",    bus.wb_empty, 1'b1);
    chk("t6_idle_cmd", bus.mem_cmd,  BUS_NONE);
    step();
    bus.mem_accept = 1'b0; bus.retire = 3'b111;
    for (int i = 0; i < 3; i++) set_wb(i, 32'h310 + 32'(i * 4), 32'h88, 4'hA);
    step();
    bus.retire = 3'b000; bus.mem_accept = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_rst_empty", bus.wb_empty, 1'b1);
    chk("t6_rst_cmd",   bus.mem_cmd,  BUS_NONE);
    chk("t6_rst_gnt",   bus.ld_gnt,   2'b00);
    chk("t6_rst_stall", bus.wb_stall, 3'b000);
    step();
    reset = 1'b1; bus.halt_drain = 1'b0; bus.ld_req = 2'b00;
    settle();
    chk("t6_post_empty", bus.wb_empty, 1'b1);
    step();

    // Random traffic; load FUs hold request and address until granted
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (gnt_seen[k]) bus.ld_req[k] = 1'b0;
        else if (!bus.ld_req[k] && $urandom_range(0, 2) == 0) begin
          bus.ld_req[k]  = 1'b1;
          bus.ld_addr[k] = rand_addr();
        end
      end
      nr = $urandom_range(0, 3);
      bus.retire = 3'((1 << nr) - 1);
      for (int i = 0; i < 3; i++) set_wb(i, rand_addr(), $urandom, 4'($urandom));
      bus.mem_accept = ($urandom_range(0, 3) != 0);
      bus.halt_drain = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
